// File: rtl/mmio_timer_pkg.sv
// Shared constants for the memory-mapped timer bank:
// register offsets and TCON bit positions.
package mmio_timer_pkg;

    localparam logic [3:0] OFF_TH   = 4'h0;
    localparam logic [3:0] OFF_TL   = 4'h4;
    localparam logic [3:0] OFF_TCON = 4'h8;
    localparam logic [3:0] OFF_PRE  = 4'hC;
    localparam logic [7:0] OFF_STAT = 8'hF0;

    localparam int TCON_EN      = 0;
    localparam int TCON_IRQ     = 1;
    localparam int TCON_ONESHOT = 2;

endpackage

// File: rtl/timer_channel.sv
// One auto-reload timer channel: reload, count, control and
// prescaler registers, producing a one-cycle overflow pulse.
module timer_channel
    import mmio_timer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_th,
    input  logic             wr_tl,
    input  logic             wr_tcon,
    input  logic             wr_pre,
    input  logic [WIDTH-1:0] wdata_cnt,
    input  logic [PRE_W-1:0] wdata_pre,
    input  logic [2:0]       wdata_tcon,
    output logic [WIDTH-1:0] th,
    output logic [WIDTH-1:0] tl,
    output logic [2:0]       tcon,
    output logic [PRE_W-1:0] pre,
    output logic             ovf
);

    logic [PRE_W-1:0] precnt;
    logic             tick;

    assign tick = tcon[TCON_EN] && (precnt == pre);
    assign ovf  = tick && (tl == {WIDTH{1'b1}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th     <= '0;
            tl     <= '0;
            tcon   <= '0;
            pre    <= '0;
            precnt <= '0;
        end else begin
            if (wr_pre || wr_tcon || !tcon[TCON_EN] || tick)
                precnt <= '0;
            else
                precnt <= precnt + 1'b1;

            if (wr_th)
                th <= wdata_cnt;

            // Bus write beats the tick; a new TH only lands on reload
            if (wr_tl)
                tl <= wdata_cnt;
            else if (ovf)
                tl <= th;
            else if (tick)
                tl <= tl + 1'b1;

            if (wr_tcon)
                tcon <= wdata_tcon;
            else if (ovf && tcon[TCON_ONESHOT])
                tcon[TCON_EN] <= 1'b0;

            if (wr_pre)
                pre <= wdata_pre;
        end
    end

endmodule

// File: rtl/mmio_timer_bank.sv
// Bank of auto-reload timers on the CPU peripheral bus with a
// W1C pending register and a single level interrupt.
module mmio_timer_bank
    import mmio_timer_pkg::*;
#(
    parameter int          N_TIMERS  = 2,
    parameter int          WIDTH     = 32,
    parameter int          PRE_W     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irqout
);

    logic             hit;
    logic             stat_sel;
    logic [3:0]       ch;
    logic [3:0]       off;
    logic [WIDTH-1:0] th   [N_TIMERS];
    logic [WIDTH-1:0] tl   [N_TIMERS];
    logic [2:0]       tcon [N_TIMERS];
    logic [PRE_W-1:0] pre  [N_TIMERS];
    logic [N_TIMERS-1:0] ovf;
    logic [N_TIMERS-1:0] irq_en;
    logic [N_TIMERS-1:0] wsel;
    logic [N_TIMERS-1:0] stat;
    logic [N_TIMERS-1:0] stat_clr;

    assign hit      = (addr[31:8] == BASE_ADDR[31:8])
                   && (addr[1:0] == 2'b00);
    assign stat_sel = hit && (addr[7:0] == OFF_STAT);
    assign ch       = addr[7:4];
    assign off      = {addr[3:2], 2'b00};

    for (genvar g = 0; g < N_TIMERS; g++) begin : g_ch
        assign wsel[g]   = wr && hit && (ch == 4'(g));
        assign irq_en[g] = tcon[g][TCON_IRQ];

        timer_channel #(
            .WIDTH (WIDTH),
            .PRE_W (PRE_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .wr_th      (wsel[g] && off == OFF_TH),
            .wr_tl      (wsel[g] && off == OFF_TL),
            .wr_tcon    (wsel[g] && off == OFF_TCON),
            .wr_pre     (wsel[g] && off == OFF_PRE),
            .wdata_cnt  (wdata[WIDTH-1:0]),
            .wdata_pre  (wdata[PRE_W-1:0]),
            .wdata_tcon (wdata[2:0]),
            .th         (th[g]),
            .tl         (tl[g]),
            .tcon       (tcon[g]),
            .pre        (pre[g]),
            .ovf        (ovf[g])
        );
    end

    assign stat_clr = (wr && stat_sel) ? wdata[N_TIMERS-1:0] : '0;

    // Overflow set takes priority over a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stat <= '0;
        else
            stat <= (stat & ~stat_clr) | ovf;
    end

    assign irqout = |(stat & irq_en);

    always_comb begin
        rdata = '0;
        if (rd && hit) begin
            if (stat_sel) begin
                rdata[N_TIMERS-1:0] = stat;
            end else begin
                for (int i = 0; i < N_TIMERS; i++) begin
                    if (ch == 4'(i)) begin
                        case (off)
                            OFF_TH:   rdata[WIDTH-1:0] = th[i];
                            OFF_TL:   rdata[WIDTH-1:0] = tl[i];
                            OFF_TCON: rdata[2:0]       = tcon[i];
                            OFF_PRE:  rdata[PRE_W-1:0] = pre[i];
                            default:  rdata = '0;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: doc/mmio_timer_bank.md
Name: mmio_timer_bank

Overview:
- Memory-mapped bank of N independent auto-reload timers with per-channel prescaler, one-shot/periodic mode and a write-1-to-clear interrupt status register.
- Sits on the CPU peripheral bus beside LED/switch/UART logic and drives a single level interrupt line to the CPU.
- Generalises the single fixed timer: channel count, counter width, prescaling and one-shot mode are new.

Parameters:
- N_TIMERS, 2, number of channels (1..15).
- WIDTH, 32, counter/reload width (8..32); registers read zero-extended to 32 bits.
- PRE_W, 8, prescaler width.
- BASE_ADDR, 32'h40000000, bank base address; must be 256-byte aligned.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rd  in  1  bus read strobe.
- wr  in  1  bus write strobe.
- addr  in  32  byte address.
- wdata  in  32  write data.
- rdata  out  32  read data (combinational).
- irqout  out  1  level interrupt, OR of enabled pending channels.

Behaviour:
- Decode: hit when addr[31:8]==BASE_ADDR[31:8] and addr[1:0]==0. Channel i = addr[7:4], register = addr[3:2].
- Per-channel offsets: 0x0 TH (reload), 0x4 TL (count), 0x8 TCON, 0xC PRE.
- TCON bits: [0] enable, [1] irq_en, [2] oneshot. Upper bits read 0.
- Bank offset 0xF0 is STAT: bit i = channel i pending. Write 1 clears; write 0 has no effect.
- Channel index >= N_TIMERS, or any other offset: reads 0, writes ignored. Misses: rdata=0.
- rdata is 0 whenever rd=0. Reads have no side effects.
- Writes commit on the next posedge clk when wr=1; write data is truncated to the register width.
- Reset: TH, TL, TCON, PRE, prescaler count and STAT all 0. irqout=0. Reset mid-count aborts immediately.
- Prescaler:
  - precnt is held at 0 while enable=0.
  - When enabled, tick asserts when precnt==PRE; precnt then returns to 0, otherwise increments.
  - PRE=0 gives a tick every cycle.
  - A write to PRE or TCON clears precnt.
- Counter, on tick:
  - If TL==all-ones: TL<=TH, STAT[i]<=1. In oneshot mode, enable<=0 in the same cycle.
  - Otherwise TL<=TL+1.
  - Period is (2^WIDTH - TH) ticks.
- STAT[i] sets on overflow regardless of irq_en.
- irqout = |(STAT & irq_en vector), registered-state only, with no combinational path from the bus.
- Simultaneous events:
  - Bus write to TL and a tick in the same cycle: the write wins.
  - W1C clear and overflow set on the same bit in the same cycle: set wins.
  - Write to TCON with enable=1 in the same cycle as a oneshot auto-disable: the written value wins.
- TH written while running takes effect at the next reload only.

Decomposition:
- Package mmio_timer_pkg holds the offset constants (OFF_TH, OFF_TL, OFF_TCON, OFF_PRE, OFF_STAT) and the TCON bit indices.
- Sub-module timer_channel (one per channel, via generate) holds TH/TL/TCON/PRE/precnt and outputs an overflow pulse.
- The top level holds address decode, read mux, STAT and irqout.

Test Plan:
- Reset then read every register of ch0/ch1 and STAT -> all read 0, irqout=0. Read 0x40000030 with N=2 -> 0.
- ch0: TH=0xFFFFFFFC, TL=0xFFFFFFFC, PRE=0, TCON=3 -> overflow on 4th cycle after the TCON write. STAT=1, irqout=1, TL reloads 0xFFFFFFFC. Write STAT=1 -> irqout=0 next cycle; re-pends 4 cycles later.
- ch1: PRE=3, TL=0xFFFFFFFE, TH=0, TCON=0b101 (oneshot, no irq) -> STAT[1]=1 after 8 cycles, TCON reads 0b100, TL=0 and stays 0. irqout stays 0.
- Collision: schedule W1C of STAT[0] on the exact cycle ch0 overflows -> STAT[0] remains 1. Schedule a TL write of 0x10 on a tick cycle -> TL reads 0x10.
- Both channels running with different TH -> STAT bits set independently. irqout follows only the channels with irq_en set.
- Assert reset while ch0 is 2 ticks from overflow -> all registers 0 asynchronously, no STAT set after release.
